// File: rtl/multiport_reg_file.sv
// multiport_reg_file: architectural register file with NRD combinational read
// ports, NWR prioritised write ports, write-first bypass, a per-register
// pending (scoreboard) bit and a one-entry-per-cycle bulk-clear engine.
//
// Handshake/sequencing: there is no valid/ready pair here. wr_en and sb_set
// are single-cycle qualifiers sampled at every posedge while IDLE. clr_req is
// a request sampled only in IDLE. clr_busy acknowledges it one cycle later and
// stays high for exactly NREGS cycles. wr_en, sb_set and clr_req are ignored
// while clr_busy is high.
module multiport_reg_file #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_pending,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_set_addr,
  input  logic                clr_req,
  output logic                clr_busy
);

  localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);
  localparam bit            HAS_Z   = (ZERO_REG != 0);

  typedef enum logic {IDLE, SWEEP} state_t;

  // state_q is the observable FSM state for checkers bound to this module.
  state_t              state_q;
  state_t              state_d;
  logic [AW-1:0]       idx_q;
  logic [XLEN-1:0]     regs_q [NREGS];
  logic [NREGS-1:0]    pend_q;
  logic [NWR-1:0]      eff_we;
  logic                sb_ok;

  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < NREGS_W);
  endfunction

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return HAS_Z && (a == '0);
  endfunction

  // A write is effective only in IDLE, to a real register, and never to x0.
  always_comb begin
    eff_we = '0;
    for (int w = 0; w < NWR; w++) begin
      eff_we[w] = wr_en[w] && (state_q == IDLE)
                  && in_range(wr_addr[w*AW +: AW])
                  && !is_zero_reg(wr_addr[w*AW +: AW]);
    end
    sb_ok = sb_set && (state_q == IDLE) && in_range(sb_set_addr)
            && !is_zero_reg(sb_set_addr);
  end

  // Clear FSM next-state: start on request in IDLE, leave after the last entry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clr_req) state_d = SWEEP;
      SWEEP:   if (idx_q == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Clear FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Storage update: reset, sweep one entry, or apply writes then scoreboard set.
  // Later ports are applied last so the highest index wins; sb_set is applied
  // after the write clears so a new producer keeps the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      pend_q <= '0;
      idx_q  <= '0;
    end else if (state_q == SWEEP) begin
      regs_q[idx_q] <= '0;
      pend_q[idx_q] <= 1'b0;
      idx_q         <= (idx_q == LAST) ? '0 : idx_q + AW'(1);
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (eff_we[w]) begin
          regs_q[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
          pend_q[wr_addr[w*AW +: AW]] <= 1'b0;
        end
      end
      if (sb_ok) pend_q[sb_set_addr] <= 1'b1;
    end
  end

  // Read ports: x0 and out-of-range read 0; otherwise stored value, overridden
  // by the highest-index effective write to the same address (bypass in IDLE).
  always_comb begin
    logic [AW-1:0] ra;
    ra         = '0;
    rd_data    = '0;
    rd_pending = '0;
    for (int p = 0; p < NRD; p++) begin
      ra = rd_addr[p*AW +: AW];
      if (!is_zero_reg(ra) && in_range(ra)) begin
        rd_data[p*XLEN +: XLEN] = regs_q[ra];
        rd_pending[p]           = pend_q[ra];
        for (int w = 0; w < NWR; w++) begin
          if (eff_we[w] && (wr_addr[w*AW +: AW] == ra)) begin
            rd_data[p*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
            rd_pending[p]           = 1'b0;
          end
        end
      end
    end
  end

  assign clr_busy = (state_q == SWEEP);

endmodule
